// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: data width, frame state encoding, byte payload type.
// Imported by the transmitter and its FIFO; the state encoding matches the rx side.
package uart_tx_fifo_pkg;

   localparam int unsigned DATA_BITS = 8;

   // Frame-level FSM states, in line order.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   typedef logic [DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk      in   system clock, rising edge
//   nrst     in   synchronous active-low reset (empties the FIFO)
//   wr_data  in   WIDTH  data written on push
//   push     in   write request; ignored when full
//   pop      in   read request; ignored when empty
//   rd_data  out  WIDTH  head entry (valid when not empty)
//   empty    out  count == 0
//   full     out  count == 2**DEPTH_LOG2
module sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage: no reset needed, contents are qualified by count.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small byte FIFO; queued frames go out back-to-back.
// Ports:
//   i_clk    in   system clock, rising edge
//   i_nrst   in   synchronous active-low reset; aborts any frame and drops queued bytes
//   i_data   in   8  byte to transmit
//   i_valid  in   i_data valid; accepted on an edge where i_valid & o_ready
//   o_ready  out  FIFO not full
//   o_busy   out  frame in progress or FIFO non-empty
//   o_tx     out  serial line, LSB first, idles high (driven from a flop)
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 12000000,
   parameter int unsigned BAUD            = 115200,
   parameter int unsigned CLKS_PER_BIT    = CLK_HZ / BAUD,
   parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
   input  logic                 i_clk,
   input  logic                 i_nrst,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_valid,
   output logic                 o_ready,
   output logic                 o_busy,
   output logic                 o_tx
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   uart_byte_t        shift_q, shift_d;
   logic              tx_q, tx_d;

   logic              pop;
   logic              push;
   logic              fifo_empty;
   logic              fifo_full;
   uart_byte_t        fifo_data;
   logic              bit_end;

   assign push    = i_valid & ~fifo_full;
   assign bit_end = (baud_q == BAUD_LAST);

   sync_fifo #(
      .WIDTH      (DATA_BITS),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk     (i_clk),
      .nrst    (i_nrst),
      .wr_data (i_data),
      .push    (push),
      .pop     (pop),
      .rd_data (fifo_data),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   // State register and datapath flops.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic. tx_d is the line level for the cycle after this edge,
   // so the line flop changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               baud_d  = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
            end
         end

         ST_START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         ST_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               if (bit_q == BIT_LAST) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         ST_STOP: begin
            if (bit_end) begin
               baud_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_data;
                  state_d = ST_START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign o_tx    = tx_q;
   assign o_ready = ~fifo_full;
   assign o_busy  = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a line-rate instance checked by a mid-bit sampling
// receiver against a queue of expected bytes, and a fast-divisor instance checked
// cycle by cycle against a queue of expected line levels.
module tb_uart_tx_fifo;

   localparam int unsigned CPB   = 104;
   localparam int unsigned CPB_F = 4;

   logic       clk = 1'b0;
   logic       nrst, valid, ready, busy, tx;
   logic [7:0] data;
   logic       nrst_f, valid_f, ready_f, busy_f, tx_f;
   logic [7:0] data_f;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_HZ(12000000), .BAUD(115200)) dut (
      .i_clk(clk), .i_nrst(nrst), .i_data(data), .i_valid(valid),
      .o_ready(ready), .o_busy(busy), .o_tx(tx));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB_F)) dut_f (
      .i_clk(clk), .i_nrst(nrst_f), .i_data(data_f), .i_valid(valid_f),
      .o_ready(ready_f), .o_busy(busy_f), .o_tx(tx_f));

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int frames = 0;
   logic [7:0] exp_q[$];
   logic       exp_bits_f[$];
   int         frame_start_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Receiver for the line-rate instance: detects the start edge, samples mid-bit.
   initial begin
      int         rx_cnt;
      logic       prev;
      logic [7:0] sh;
      bit         active;
      rx_cnt = 0; prev = 1'b1; sh = '0; active = 1'b0;
      forever begin
         @(negedge clk);
         if (nrst !== 1'b1) begin
            active = 1'b0;
            prev   = 1'b1;
         end else begin
            if (!active) begin
               if (prev === 1'b1 && tx === 1'b0) begin
                  active = 1'b1;
                  rx_cnt = 0;
                  frame_start_q.push_back(cyc);
               end
            end else begin
               rx_cnt++;
               if (rx_cnt == CPB / 2) begin
                  check("rx_start_bit", 32'(tx), 32'h0);
               end else if (rx_cnt > CPB / 2 && (rx_cnt - CPB / 2) % CPB == 0) begin
                  int k;
                  k = (rx_cnt - CPB / 2) / CPB;
                  if (k <= 8) begin
                     sh[k-1] = tx;
                  end else begin
                     check("rx_stop_bit", 32'(tx), 32'h1);
                     if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_frame actual=%02h required=none", sh);
                     end else begin
                        check("rx_byte", 32'(sh), 32'(exp_q.pop_front()));
                     end
                     frames++;
                     active = 1'b0;
                  end
               end
            end
            prev = tx;
         end
      end
   end

   // Cycle-exact line compare for the fast instance.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_bits_f.size() > 0) begin
            logic e;
            e = exp_bits_f.pop_front();
            check("fast_tx_bit", 32'(tx_f), 32'(e));
         end
      end
   end

   task automatic push_frame_f(input logic [7:0] b);
      for (int i = 0; i < 10; i++) begin
         logic bv;
         bv = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
         repeat (CPB_F) exp_bits_f.push_back(bv);
      end
   endtask

   task automatic wait_frames(input int n, input int budget, input string name);
      int g;
      g = 0;
      while (frames < n && g < budget) begin
         @(negedge clk);
         g++;
      end
      check(name, 32'(frames), 32'(n));
   endtask

   initial begin
      int base, cnt, lows, g, idx, acc, acc_at_stall;
      int acc_cyc[6];
      logic r;

      nrst = 1'b0; valid = 1'b0; data = '0;
      nrst_f = 1'b0; valid_f = 1'b0; data_f = '0;

      // 1. reset
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1; nrst_f = 1'b1;
      @(negedge clk);
      check("reset_tx", 32'(tx), 32'h1);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_ready", 32'(ready), 32'h1);
      check("reset_ready_f", 32'(ready_f), 32'h1);
      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("idle_line_low_cycles", 32'(lows), 32'h0);

      // 2. single byte 8'h11, latency and busy duration
      base = frames;
      @(posedge clk);
      #1 data = 8'h11; valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      exp_q.push_back(8'h11);
      @(negedge clk);
      check("lat_tx_before_pop", 32'(tx), 32'h1);
      check("lat_busy_after_accept", 32'(busy), 32'h1);
      @(negedge clk);
      check("lat_tx_fall", 32'(tx), 32'h0);
      cnt = 0;
      while (busy && cnt < 3000) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(cnt), 32'(10 * CPB));
      wait_frames(base + 1, 200, "single_frames");

      // 3. back-to-back 8'h33, 8'hEE
      repeat (20) @(negedge clk);
      base = frames;
      frame_start_q.delete();
      @(posedge clk);
      #1 data = 8'h33; valid = 1'b1;
      @(posedge clk);
      #1 data = 8'hEE;
      exp_q.push_back(8'h33);
      @(posedge clk);
      #1 valid = 1'b0;
      exp_q.push_back(8'hEE);
      wait_frames(base + 2, 25 * CPB, "b2b_frames");
      check("b2b_start_count", 32'(frame_start_q.size()), 32'd2);
      if (frame_start_q.size() >= 2)
         check("b2b_gap", 32'(frame_start_q[1] - frame_start_q[0]), 32'(10 * CPB));

      // 4. overflow: hold valid for 01..06
      repeat (3 * CPB) @(negedge clk);
      base = frames;
      @(posedge clk);
      #1;
      idx = 1; data = 8'(idx); valid = 1'b1; acc = 0; acc_at_stall = -1; g = 0;
      foreach (acc_cyc[i]) acc_cyc[i] = 0;
      while (idx <= 6 && g < 4000) begin
         @(negedge clk);
         r = ready;
         if (!r && acc_at_stall < 0) acc_at_stall = acc;
         @(posedge clk);
         #1;
         g++;
         if (r) begin
            exp_q.push_back(8'(idx));
            acc_cyc[idx-1] = cyc;
            acc++;
            idx++;
            data = 8'(idx);
         end
      end
      valid = 1'b0;
      check("ovf_accepted_before_stall", 32'(acc_at_stall), 32'd5);
      check("ovf_all_accepted", 32'(acc), 32'd6);
      check("ovf_stall_release", 32'(acc_cyc[5] - acc_cyc[0]), 32'(10 * CPB + 2));
      wait_frames(base + 6, 70 * CPB, "ovf_frames");

      // 5. reset during data bit 3 of 8'hEE with two bytes queued
      repeat (3 * CPB) @(negedge clk);
      base = frames;
      @(posedge clk);
      #1 data = 8'hEE; valid = 1'b1;
      @(posedge clk);
      #1 data = 8'h12;
      @(posedge clk);
      #1 data = 8'h34;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (4 * CPB + 40) @(posedge clk);
      #1;
      check("mid_busy_before_reset", 32'(busy), 32'h1);
      nrst = 1'b0;
      @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      check("mid_reset_tx", 32'(tx), 32'h1);
      check("mid_reset_busy", 32'(busy), 32'h0);
      check("mid_reset_ready", 32'(ready), 32'h1);
      lows = 0;
      cnt = 0;
      repeat (3000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) cnt++;
      end
      check("mid_after_reset_low_cycles", 32'(lows), 32'h0);
      check("mid_after_reset_busy_cycles", 32'(cnt), 32'h0);
      check("mid_no_frames", 32'(frames), 32'(base));

      // 6. fast divisor stream 8'hA5, 8'h5A
      @(posedge clk);
      #1 data_f = 8'hA5; valid_f = 1'b1;
      @(posedge clk);
      #1;
      exp_bits_f.push_back(1'b1);
      push_frame_f(8'hA5);
      push_frame_f(8'h5A);
      repeat (6) exp_bits_f.push_back(1'b1);
      data_f = 8'h5A;
      @(posedge clk);
      #1 valid_f = 1'b0;
      g = 0;
      while (exp_bits_f.size() > 0 && g < 500) begin
         @(negedge clk);
         g++;
      end
      check("fast_queue_drained", 32'(exp_bits_f.size()), 32'h0);
      check("fast_busy_end", 32'(busy_f), 32'h0);

      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
